// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response/kill bundle between execute stage and mul_div_unit
interface mul_div_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_fn;
  logic [XLEN-1:0]  req_in1;
  logic [XLEN-1:0]  req_in2;
  logic [TAG_W-1:0] req_tag;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output req_valid, req_fn, req_in1, req_in2, req_tag, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, busy
  );

  modport slave (
    input  req_valid, req_fn, req_in1, req_in2, req_tag, kill, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 RV32M multiply/divide unit
// Works on operand magnitudes; signs are reapplied in the single FIX cycle.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  mul_div_unit_if.slave  io
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        fn_q, fn_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg1_q, neg1_d;
  logic              neg2_q, neg2_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              sgn1, sgn2, req_neg1, req_neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (io.req_valid) state_d = ITER;
      ITER: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (io.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Kill only aborts work in flight; an IDLE request still goes through.
    if (io.kill && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    io.req_ready  = (state_q == IDLE);
    io.resp_valid = (state_q == DONE);
    io.busy       = (state_q != IDLE);
    io.resp_data  = res_q;
    io.resp_tag   = tag_q;
  end

  always_comb begin
    sgn1     = (io.req_fn == 4'd1) || (io.req_fn == 4'd2) || (io.req_fn == 4'd4) || (io.req_fn == 4'd6);
    sgn2     = (io.req_fn == 4'd1) || (io.req_fn == 4'd4) || (io.req_fn == 4'd6);
    req_neg1 = sgn1 && io.req_in1[XLEN-1];
    req_neg2 = sgn2 && io.req_in2[XLEN-1];
    mag1     = req_neg1 ? -io.req_in1 : io.req_in1;
    mag2     = req_neg2 ? -io.req_in2 : io.req_in2;

    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[XLEN-1:0] - b_q;

    prod     = {acc_q, lo_q};
    prod_fix = (neg1_q ^ neg2_q) ? -prod : prod;
    quo_fix  = ((neg1_q ^ neg2_q) && b_q != '0) ? -lo_q : lo_q;
    rem_fix  = neg1_q ? -acc_q : acc_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    fn_d   = fn_q;
    tag_d  = tag_q;
    neg1_d = neg1_q;
    neg2_d = neg2_q;
    b_d    = b_q;
    lo_d   = lo_q;
    acc_d  = acc_q;
    res_d  = res_q;
    unique case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          cnt_d  = '0;
          fn_d   = io.req_fn;
          tag_d  = io.req_tag;
          neg1_d = req_neg1;
          neg2_d = req_neg2;
          lo_d   = mag1;
          b_d    = mag2;
          acc_d  = '0;
        end
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (fn_q[3:2] == 2'b01) begin
          // Restoring divide: quotient bits shift into lo as dividend bits leave.
          acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      FIX: begin
        unique case (fn_q)
          4'd0:                res_d = prod_fix[XLEN-1:0];
          4'd1, 4'd2, 4'd3:    res_d = prod_fix[2*XLEN-1:XLEN];
          4'd4, 4'd5:          res_d = quo_fix;
          4'd6, 4'd7:          res_d = rem_fix;
          default:             res_d = '0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      fn_q   <= '0;
      tag_q  <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      b_q    <= '0;
      lo_q   <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fn_q   <= fn_d;
      tag_q  <= tag_d;
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
      b_q    <= b_d;
      lo_q   <= lo_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - vector table, corner sequences and random ops for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

  mul_div_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clock   (clk),
    .reset_n (rstn),
    .io      (bus)
  );

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = $signed(ub);
    case (fn)
      4'd0: begin p = ua * ub; return p[31:0]; end
      4'd1: begin p = sa * sb; return p[63:32]; end
      4'd2: begin p = sa * sub; return p[63:32]; end
      4'd3: begin p = ua * ub; return p[63:32]; end
      4'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      4'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      4'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      4'd7: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Ends at the falling edge of cycle 1 (the cycle after the request fired).
  task automatic do_req(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_fn    = fn;
    bus.req_in1   = a;
    bus.req_in2   = b;
    bus.req_tag   = tag;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic [4:0] t, output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    d = bus.resp_data;
    t = bus.resp_tag;
  endtask

  task automatic finish_resp(input string name);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({name, "_idle_after"}, {62'd0, bus.busy, bus.resp_valid}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    logic [31:0] d;
    logic [4:0]  t;
    int          lat;
    do_req(fn, a, b, tag);
    wait_resp(d, t, lat);
    check({name, "_lat"}, 64'(lat), 64'd34);
    check({name, "_data"}, 64'(d), 64'(exp));
    check({name, "_tag"}, 64'(t), 64'(tag));
    finish_resp(name);
  endtask

  initial begin
    logic [31:0] d, d0;
    logic [4:0]  t, t0;
    int          lat;
    logic        seen;

    vecs[0]  = '{4'd0, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    vecs[1]  = '{4'd1, 32'h80000000,  32'h80000000, 5'd1,  32'h40000000};
    vecs[2]  = '{4'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
    vecs[3]  = '{4'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
    vecs[4]  = '{4'd4, 32'hFFFFFFF9,  32'd2,        5'd4,  32'hFFFFFFFD};
    vecs[5]  = '{4'd6, 32'hFFFFFFF9,  32'd2,        5'd6,  32'hFFFFFFFF};
    vecs[6]  = '{4'd5, 32'd100,       32'd7,        5'd7,  32'd14};
    vecs[7]  = '{4'd7, 32'd100,       32'd7,        5'd8,  32'd2};
    vecs[8]  = '{4'd4, 32'd5,         32'd0,        5'd9,  32'hFFFFFFFF};
    vecs[9]  = '{4'd6, 32'd5,         32'd0,        5'd10, 32'd5};
    vecs[10] = '{4'd4, 32'hFFFFFFFB,  32'd0,        5'd11, 32'hFFFFFFFF};
    vecs[11] = '{4'd4, 32'h80000000,  32'hFFFFFFFF, 5'd12, 32'h80000000};
    vecs[12] = '{4'd6, 32'h80000000,  32'hFFFFFFFF, 5'd13, 32'd0};
    vecs[13] = '{4'd9, 32'd123,       32'd456,      5'd31, 32'd0};

    bus.req_valid  = 1'b0;
    bus.req_fn     = 4'd0;
    bus.req_in1    = 32'd0;
    bus.req_in2    = 32'd0;
    bus.req_tag    = 5'd0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.resp_valid, bus.busy, bus.resp_tag, bus.resp_data}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

    // Backpressure with a second request held pending during DONE
    do_req(4'd0, 32'd6, 32'd9, 5'd21);
    wait_resp(d0, t0, lat);
    check("bp_lat", 64'(lat), 64'd34);
    check("bp_data", 64'(d0), 64'd54);
    bus.req_valid = 1'b1;
    bus.req_fn    = 4'd5;
    bus.req_in1   = 32'd100;
    bus.req_in2   = 32'd7;
    bus.req_tag   = 5'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {bus.resp_valid, bus.req_ready, 25'd0, bus.resp_tag, bus.resp_data},
            {1'b1, 1'b0, 25'd0, 5'd21, 32'd54});
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_released", {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_resp(d, t, lat);
    check("bp_next_lat", 64'(lat), 64'd34);
    check("bp_next_data", 64'(d), 64'd14);
    check("bp_next_tag", 64'(t), 64'd9);
    finish_resp("bp_next");

    // Kill at counter 10 (cycle 11)
    do_req(4'd1, 32'h12345678, 32'h9ABCDEF0, 5'd17);
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_idle", {62'd0, bus.busy, bus.req_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("kill_no_resp", 64'(seen), 64'd0);

    // Kill in IDLE must not block a same-cycle request
    bus.kill = 1'b1;
    do_req(4'd0, 32'd11, 32'd13, 5'd14);
    bus.kill = 1'b0;
    wait_resp(d, t, lat);
    check("idle_kill_lat", 64'(lat), 64'd34);
    check("idle_kill_data", 64'(d), 64'd143);
    finish_resp("idle_kill");

    // Kill together with the response handshake
    do_req(4'd7, 32'd50, 32'd8, 5'd15);
    wait_resp(d, t, lat);
    check("kill_hs_data", 64'(d), 64'd2);
    bus.kill = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    bus.resp_ready = 1'b0;
    check("kill_hs_idle", {61'd0, bus.busy, bus.resp_valid, bus.req_ready}, 64'd1);

    // Reset at counter 20 (cycle 21)
    do_req(4'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd27);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {bus.resp_valid, bus.busy, bus.resp_tag, bus.resp_data}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_req_ready", 64'(bus.req_ready), 64'd1);
    run_op("post_reset_mul", 4'd0, 32'd3, 32'd4, 5'd3, 32'd12);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  fn;
      logic [31:0] a, b;
      fn = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_fn%0d", i, fn), fn, a, b, 5'($urandom_range(0, 31)), ref_model(fn, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
